button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/debounce_channel.sv | 86 ++++++++
 rtl/button_conditioner.sv | 46 ++++
 tb/tb_button_conditioner.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch front end: button indices and the
// per-channel debounce state encoding.
package stopwatch_pkg;

   localparam int NUM_BTNS = 4;

   typedef enum logic [1:0] {
      BTN_ONE   = 2'd0,
      BTN_TEN   = 2'd1,
      BTN_PAUSE = 2'd2,
      BTN_CLEAR = 2'd3
   } btn_e;

   typedef enum logic [1:0] {
      DB_IDLE,
      DB_PRESS_WAIT,
      DB_HELD,
      DB_RELEASE_WAIT
   } db_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One pushbutton channel: 2-flop synchronizer, press/release debounce FSM,
// registered debounced level and a single-cycle pulse on each accepted press.
module debounce_channel
   import stopwatch_pkg::*;
#(
   parameter int DB_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic press,
   output logic level
);

   localparam int            CW       = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic            sync_p0;
   logic            sync_p1;
   db_state_e       state;
   logic [CW-1:0]   cnt;

   // Saturating increment: the counter parks at its terminal value
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_LAST) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         state   <= DB_IDLE;
         cnt     <= '0;
         press   <= 1'b0;
         level   <= 1'b0;
      end else begin
         // synchronizer stage boundary: only sync_p1 feeds the FSM
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         press   <= 1'b0;
         case (state)
            DB_IDLE: begin
               if (sync_p1) begin
                  state <= DB_PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            DB_PRESS_WAIT: begin
               if (!sync_p1) begin
                  state <= DB_IDLE;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= DB_HELD;
                  press <= 1'b1;
                  level <= 1'b1;
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end
            DB_HELD: begin
               if (!sync_p1) begin
                  state <= DB_RELEASE_WAIT;
                  cnt   <= '0;
               end
            end
            DB_RELEASE_WAIT: begin
               if (sync_p1) begin
                  state <= DB_HELD;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= DB_IDLE;
                  level <= 1'b0;
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end
            default: begin
               state <= DB_IDLE;
               cnt   <= '0;
               level <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Four independent debounced button channels; a clear press suppresses any
// other press pulse landing in the same cycle.
module button_conditioner
   import stopwatch_pkg::*;
#(
   parameter int DB_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       one_button,
   input  logic       ten_button,
   input  logic       pause_button,
   input  logic       clear_button,
   output logic       one_press,
   output logic       ten_press,
   output logic       pause_press,
   output logic       clear_press,
   output logic [3:0] btn_level
);

   logic [NUM_BTNS-1:0] raw_btn;
   logic [NUM_BTNS-1:0] ch_press;
   logic [NUM_BTNS-1:0] ch_level;

   assign raw_btn = {clear_button, pause_button, ten_button, one_button};

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
      debounce_channel #(
         .DB_CYCLES(DB_CYCLES)
      ) u_ch (
         .clk  (clk),
         .rst  (rst),
         .raw  (raw_btn[i]),
         .press(ch_press[i]),
         .level(ch_level[i])
      );
   end

   // Clear takes priority; masked channels keep advancing internally
   assign clear_press = ch_press[BTN_CLEAR];
   assign one_press   = ch_press[BTN_ONE]   & ~ch_press[BTN_CLEAR];
   assign ten_press   = ch_press[BTN_TEN]   & ~ch_press[BTN_CLEAR];
   assign pause_press = ch_press[BTN_PAUSE] & ~ch_press[BTN_CLEAR];
   assign btn_level   = ch_level;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB_CYCLES = 8; expected press
// pulses are queued with their due cycle and checked as the DUT produces them.
module tb_button_conditioner;

   localparam int DB = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       one_button, ten_button, pause_button, clear_button;
   logic       one_press, ten_press, pause_press, clear_press;
   logic [3:0] btn_level;
   logic [3:0] presses;

   typedef struct {
      int         cyc;
      logic [3:0] vec;
   } exp_t;

   exp_t expq[$];
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   button_conditioner #(.DB_CYCLES(DB)) dut (
      .clk         (clk),
      .rst         (rst),
      .one_button  (one_button),
      .ten_button  (ten_button),
      .pause_button(pause_button),
      .clear_button(clear_button),
      .one_press   (one_press),
      .ten_press   (ten_press),
      .pause_press (pause_press),
      .clear_press (clear_press),
      .btn_level   (btn_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // Advance one edge, then compare press outputs against the scoreboard
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      presses = {clear_press, pause_press, ten_press, one_press};
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
         chk("press_pulse", {28'd0, presses}, {28'd0, expq[0].vec});
         void'(expq.pop_front());
      end else if (presses != 4'b0000) begin
         chk("spurious_press", {28'd0, presses}, 32'd0);
      end
   endtask

   task automatic run_until(input int n);
      while (cyc < n) tick();
   endtask

   // Input changed now is first sampled at the next edge; pulse follows DB+2 edges later
   task automatic expect_press(input logic [3:0] v);
      expq.push_back('{cyc + DB + 3, v});
   endtask

   initial begin
      int c;
      rst = 1'b1;
      one_button = 1'b0; ten_button = 1'b0; pause_button = 1'b0; clear_button = 1'b0;
      repeat (3) tick();
      chk("reset_level", {28'd0, btn_level}, 32'd0);
      chk("reset_press", {28'd0, clear_press, pause_press, ten_press, one_press}, 32'd0);
      rst = 1'b0;

      // Clean press sampled from edge 10: pulse after edge 20
      run_until(9);
      one_button = 1'b1;
      expect_press(4'b0001);
      run_until(19);
      chk("one_level_before", {28'd0, btn_level}, 32'd0);
      tick();
      chk("one_level_held", {28'd0, btn_level}, 32'h1);
      tick();
      chk("one_level_after", {28'd0, btn_level}, 32'h1);
      c = cyc;
      one_button = 1'b0;
      run_until(c + 10);
      chk("one_release_wait", {28'd0, btn_level}, 32'h1);
      tick();
      chk("one_release_done", {28'd0, btn_level}, 32'h0);
      repeat (5) tick();

      // Short glitches on ten: never accepted
      for (int i = 0; i < 3; i++) begin
         ten_button = 1'b1;
         repeat (5) tick();
         chk("ten_glitch_level", {28'd0, btn_level}, 32'h0);
         ten_button = 1'b0;
         repeat (3) tick();
      end
      repeat (10) tick();
      chk("ten_glitch_final", {28'd0, btn_level}, 32'h0);

      // Long pause hold: exactly one pulse
      pause_button = 1'b1;
      expect_press(4'b0100);
      repeat (3000) tick();
      chk("pause_long_level", {28'd0, btn_level}, 32'h4);
      c = cyc;
      pause_button = 1'b0;
      run_until(c + 10);
      chk("pause_release_wait", {28'd0, btn_level}, 32'h4);
      tick();
      chk("pause_release_done", {28'd0, btn_level}, 32'h0);
      repeat (5) tick();

      // Release bounce then re-press while held: no second pulse
      c = cyc;
      one_button = 1'b1;
      expect_press(4'b0001);
      run_until(c + 13);
      one_button = 1'b0;
      repeat (3) tick();
      one_button = 1'b1;
      repeat (20) tick();
      chk("bounce_level", {28'd0, btn_level}, 32'h1);
      c = cyc;
      one_button = 1'b0;
      run_until(c + 11);
      chk("bounce_release_done", {28'd0, btn_level}, 32'h0);
      repeat (5) tick();

      // One and clear together: clear masks one
      c = cyc;
      one_button = 1'b1;
      clear_button = 1'b1;
      expect_press(4'b1000);
      run_until(c + 11);
      chk("clear_mask_level", {28'd0, btn_level}, 32'h9);
      one_button = 1'b0;
      clear_button = 1'b0;
      repeat (15) tick();
      chk("clear_mask_release", {28'd0, btn_level}, 32'h0);

      // One and ten together: no masking
      one_button = 1'b1;
      ten_button = 1'b1;
      expect_press(4'b0011);
      repeat (12) tick();
      chk("one_ten_level", {28'd0, btn_level}, 32'h3);
      one_button = 1'b0;
      ten_button = 1'b0;
      repeat (15) tick();

      // Reset during PRESS_WAIT with button still held: re-debounce
      c = cyc;
      one_button = 1'b1;
      run_until(c + 6);
      rst = 1'b1;
      repeat (3) tick();
      chk("mid_reset_level", {28'd0, btn_level}, 32'h0);
      rst = 1'b0;
      expect_press(4'b0001);
      repeat (10) tick();
      chk("post_reset_wait", {28'd0, btn_level}, 32'h0);
      tick();
      chk("post_reset_level", {28'd0, btn_level}, 32'h1);
      one_button = 1'b0;
      repeat (15) tick();

      chk("queue_drained", expq.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
